instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 186 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Byte-addressed instruction fetch unit with an internal program memory.
// A request presents the byte address of an opcode. The unit reads the opcode
// and, when it is the inline-constant opcode, the CONST_BYTES bytes that
// follow it. It then returns opcode, big-endian constant and the address of
// the next opcode through a valid/ready response handshake.
//
// Parameters
//   ADDR_W       byte-address width of the program counter
//   DEPTH        program bytes stored (power of two, <= 2**ADDR_W, >= 2)
//   CONST_BYTES  length of the inline constant that follows PUSH_OPCODE
//   PUSH_OPCODE  opcode that carries an inline constant
//
// Ports
//   clk              single clock, rising edge
//   rst_n            synchronous active-low reset
//   req_valid/ready  fetch request handshake (ready only while idle)
//   req_pc           byte address of the opcode to fetch
//   rsp_valid/ready  response handshake; rsp_* held stable while waiting
//   rsp_instruction  fetched opcode
//   rsp_constant     inline constant (big-endian), zero for other opcodes
//   rsp_next_pc      address of the following opcode (wraps mod 2**ADDR_W)
//   rsp_error        sticky out-of-range flag for the current fetch
//   wr_en/addr/data  program-load port, one byte per cycle, any state
//
// Configuration
//   FETCH_BOUNDS_CHECK_EN  when defined, reads at addresses >= DEPTH return
//                          8'hFF and raise rsp_error, and writes there are
//                          dropped. When undefined, addresses alias onto the
//                          low log2(DEPTH) bits and rsp_error stays 0.
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int         ADDR_W      = 8,
  parameter int         DEPTH       = 256,
  parameter int         CONST_BYTES = 4,
  parameter logic [7:0] PUSH_OPCODE = 8'h10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_instruction,
  output logic [8*CONST_BYTES-1:0] rsp_constant,
  output logic [ADDR_W-1:0]        rsp_next_pc,
  output logic                     rsp_error,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [7:0]               wr_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = 8 * CONST_BYTES;
  localparam int CNT_W = (CONST_BYTES > 1) ? $clog2(CONST_BYTES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CONST_BYTES - 1);
  localparam logic [ADDR_W-1:0] OP_LEN   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PUSH_LEN = ADDR_W'(CONST_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPCODE = 2'd1,
    CONST  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] addr;     // byte currently being read
  logic [ADDR_W-1:0] pc;       // opcode address of the fetch in flight
  logic [CNT_W-1:0]  cnt;      // constant bytes already shifted in
  logic [7:0]        rd_byte;
  logic              rd_err;
  logic              wr_ok;

  // Memory read is combinational from the fetch address.
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  always_comb begin
    rd_err  = ({1'b0, addr} >= DEPTH_EXT);
    rd_byte = rd_err ? 8'hFF : mem[addr[IDX_W-1:0]];
    wr_ok   = ({1'b0, wr_addr} < DEPTH_EXT);
  end
`else
  assign rd_err  = 1'b0;
  assign rd_byte = mem[addr[IDX_W-1:0]];
  assign wr_ok   = 1'b1;
`endif

  // Program memory is never cleared; writes are blocked only while in reset.
  // The non-blocking update means a read in the same cycle sees the old byte.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en && wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = OPCODE;
        end
      end
      OPCODE: begin
        state_nxt = (rd_byte == PUSH_OPCODE) ? CONST : RESP;
      end
      CONST: begin
        if (cnt == CNT_LAST) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Response fields only change while a fetch is in flight, so
  // they hold steady throughout RESP regardless of rsp_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_instruction <= '0;
      rsp_constant    <= '0;
      rsp_next_pc     <= '0;
      rsp_error       <= 1'b0;
      cnt             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr         <= req_pc;
            pc           <= req_pc;
            rsp_constant <= '0;
            rsp_error    <= 1'b0;
          end
        end
        OPCODE: begin
          rsp_instruction <= rd_byte;
          rsp_constant    <= '0;
          rsp_error       <= rsp_error | rd_err;
          addr            <= addr + OP_LEN;
          cnt             <= '0;
          if (rd_byte != PUSH_OPCODE) begin
            rsp_next_pc <= pc + OP_LEN;
          end
        end
        CONST: begin
          // Shift left a byte at a time so the first byte read ends up most
          // significant (big-endian constant).
          rsp_constant <= (rsp_constant << 8) | CW'(rd_byte);
          rsp_error    <= rsp_error | rd_err;
          addr         <= addr + OP_LEN;
          cnt          <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            rsp_next_pc <= pc + PUSH_LEN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Two instances share the clock and reset: index 0 uses the default geometry
// (ADDR_W=8, DEPTH=256), index 1 uses DEPTH=128 so that out-of-range and
// aliasing behaviour can be observed. A byte-array reference model predicts
// every fetch from the opcode/constant rules directly.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [7:0]  req_pc [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [7:0]  rsp_instruction [2];
  logic [31:0] rsp_constant [2];
  logic [7:0]  rsp_next_pc [2];
  logic        rsp_error [2];
  logic        wr_en [2];
  logic [7:0]  wr_addr [2];
  logic [7:0]  wr_data [2];

  instruction_fetch u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_pc(req_pc[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_instruction(rsp_instruction[0]), .rsp_constant(rsp_constant[0]),
    .rsp_next_pc(rsp_next_pc[0]), .rsp_error(rsp_error[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0])
  );

  instruction_fetch #(.DEPTH(128)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_pc(req_pc[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_instruction(rsp_instruction[1]), .rsp_constant(rsp_constant[1]),
    .rsp_next_pc(rsp_next_pc[1]), .rsp_error(rsp_error[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1])
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one byte array per instance.
  logic [7:0] mdl [2][256];

  function automatic int depth_of(input int sel);
    return (sel == 0) ? 256 : 128;
  endfunction

  function automatic void mwrite(input int sel, input logic [7:0] a, input logic [7:0] d);
    int dp = depth_of(sel);
    if (BOUNDS && int'(a) >= dp) return;
    mdl[sel][int'(a) % dp] = d;
  endfunction

  function automatic logic [7:0] mread(input int sel, input logic [7:0] a, output logic e);
    int dp = depth_of(sel);
    if (BOUNDS && int'(a) >= dp) begin
      e = 1'b1;
      return 8'hFF;
    end
    e = 1'b0;
    return mdl[sel][int'(a) % dp];
  endfunction

  function automatic void predict(input int sel, input logic [7:0] pc,
                                  output logic [7:0] ins, output logic [31:0] c,
                                  output logic [7:0] np, output logic er, output int lat);
    logic e;
    ins = mread(sel, pc, e);
    er  = e;
    c   = 32'h0;
    if (ins == 8'h10) begin
      for (int i = 1; i <= 4; i++) begin
        c  = {c[23:0], mread(sel, pc + 8'(i), e)};
        er = er | e;
      end
      np  = pc + 8'd5;
      lat = 5;
    end else begin
      np  = pc + 8'd1;
      lat = 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [7:0] a, input logic [7:0] d);
    wr_en[sel] = 1'b1; wr_addr[sel] = a; wr_data[sel] = d;
    @(posedge clk); #1;
    wr_en[sel] = 1'b0;
    mwrite(sel, a, d);
  endtask

  task automatic chk_reset_state(input int sel, input string tag);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid[sel]), 32'd0);
    chk({tag, ".req_ready"}, 32'(req_ready[sel]), 32'd1);
    chk({tag, ".instr"},     32'(rsp_instruction[sel]), 32'd0);
    chk({tag, ".const"},     rsp_constant[sel], 32'd0);
    chk({tag, ".next_pc"},   32'(rsp_next_pc[sel]), 32'd0);
    chk({tag, ".error"},     32'(rsp_error[sel]), 32'd0);
  endtask

  // One complete fetch: request, wait (bounded) for the response, optionally
  // stall with rsp_ready=0 for `hold` cycles, then handshake.
  task automatic run_fetch(input int sel, input logic [7:0] pc, input int hold, input bit keep,
                           input logic [7:0] e_ins, input logic [31:0] e_c,
                           input logic [7:0] e_np, input logic e_er, input int e_lat,
                           input string tag);
    int lat;
    bit stable;
    logic [7:0] c_ins, c_np;
    logic [31:0] c_c;
    logic c_er;
    chk({tag, ".req_ready_idle"}, 32'(req_ready[sel]), 32'd1);
    req_pc[sel] = pc; req_valid[sel] = 1'b1; rsp_ready[sel] = 1'b0;
    @(posedge clk); #1;
    wr_en[sel] = 1'b0;
    if (!keep) req_valid[sel] = 1'b0;
    lat = 0;
    while (rsp_valid[sel] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ".instr"},   32'(rsp_instruction[sel]), 32'(e_ins));
    chk({tag, ".const"},   rsp_constant[sel], e_c);
    chk({tag, ".next_pc"}, 32'(rsp_next_pc[sel]), 32'(e_np));
    chk({tag, ".error"},   32'(rsp_error[sel]), 32'(e_er));
    c_ins = rsp_instruction[sel]; c_c = rsp_constant[sel];
    c_np = rsp_next_pc[sel]; c_er = rsp_error[sel];
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[sel] !== 1'b1 || req_ready[sel] !== 1'b0 ||
          rsp_instruction[sel] !== c_ins || rsp_constant[sel] !== c_c ||
          rsp_next_pc[sel] !== c_np || rsp_error[sel] !== c_er) stable = 1'b0;
    end
    if (hold > 0) chk({tag, ".stall_stable"}, 32'(stable), 32'd1);
    rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[sel] = 1'b0;
    chk({tag, ".valid_drop"}, 32'(rsp_valid[sel]), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready[sel]), 32'd1);
    req_valid[sel] = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  ins;
    logic [31:0] c;
    logic [7:0]  np;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0]  p_ins, p_np, prog [8];
    logic [31:0] p_c;
    logic        p_er;
    int          p_lat;

    tbl[0] = '{8'h00, 8'h10, 32'h0000_0006, 8'h05, 5};
    tbl[1] = '{8'h05, 8'h20, 32'h0,         8'h06, 1};
    tbl[2] = '{8'h06, 8'h20, 32'h0,         8'h07, 1};
    tbl[3] = '{8'h07, 8'hFF, 32'h0,         8'h08, 1};
    tbl[4] = '{8'h04, 8'h06, 32'h0,         8'h05, 1};
    tbl[5] = '{8'h01, 8'h00, 32'h0,         8'h02, 1};
    prog = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h06, 8'h20, 8'h20, 8'hFF};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_pc[s] = 8'h0; rsp_ready[s] = 1'b0;
      wr_en[s] = 1'b0; wr_addr[s] = 8'h0; wr_data[s] = 8'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state(0, "reset0");
    chk_reset_state(1, "reset1");
    rst_n = 1'b1;

    // Random program image on both instances, biased toward push opcodes.
    for (int a = 0; a < 256; a++) begin
      for (int s = 0; s < 2; s++) begin
        wr_en[s] = 1'b1; wr_addr[s] = 8'(a);
        wr_data[s] = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom);
      end
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        wr_en[s] = 1'b0;
        mwrite(s, wr_addr[s], wr_data[s]);
      end
    end

    for (int i = 0; i < 8; i++) wr(0, 8'(i), prog[i]);
    for (int i = 0; i < 6; i++)
      run_fetch(0, tbl[i].pc, 0, 1'b0, tbl[i].ins, tbl[i].c, tbl[i].np, 1'b0,
                tbl[i].lat, $sformatf("vec%0d", i));

    // Stalled consumer with a request continuously offered.
    run_fetch(0, 8'h05, 4, 1'b1, 8'h20, 32'h0, 8'h06, 1'b0, 1, "stall");

    // Same-cycle write and read of the opcode byte returns the old byte.
    wr(0, 8'h40, 8'h20);
    req_pc[0] = 8'h40; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wr_en[0] = 1'b1; wr_addr[0] = 8'h40; wr_data[0] = 8'h10;
    @(posedge clk); #1;
    wr_en[0] = 1'b0;
    mwrite(0, 8'h40, 8'h10);
    chk("rdw.valid", 32'(rsp_valid[0]), 32'd1);
    chk("rdw.instr", 32'(rsp_instruction[0]), 32'h20);
    chk("rdw.next_pc", 32'(rsp_next_pc[0]), 32'h41);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    predict(0, 8'h40, p_ins, p_c, p_np, p_er, p_lat);
    run_fetch(0, 8'h40, 0, 1'b0, 8'h10, p_c, 8'h45, 1'b0, 5, "rdw_after");

    // Constant bytes wrapping past the top of the address space.
    wr(0, 8'hFE, 8'h10); wr(0, 8'hFF, 8'h11);
    wr(0, 8'h00, 8'h22); wr(0, 8'h01, 8'h33); wr(0, 8'h02, 8'h44);
    run_fetch(0, 8'hFE, 0, 1'b0, 8'h10, 32'h1122_3344, 8'h03, 1'b0, 5, "wrap");

    // Push straddling the end of a 128-byte memory.
    wr(1, 8'h7E, 8'h10); wr(1, 8'h7F, 8'hAB);
    wr(1, 8'h00, 8'h01); wr(1, 8'h01, 8'h02); wr(1, 8'h02, 8'h03);
    run_fetch(1, 8'h7E, 0, 1'b0, 8'h10, BOUNDS ? 32'hABFF_FFFF : 32'hAB01_0203,
              8'h83, BOUNDS, 5, "edge128");

    // Reset in the middle of a constant read aborts the fetch.
    for (int i = 0; i < 8; i++) wr(0, 8'(i), prog[i]);
    req_pc[0] = 8'h00; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    wr_en[0] = 1'b1; wr_addr[0] = 8'h04; wr_data[0] = 8'h99;
    @(posedge clk); #1;
    rst_n = 1'b1; wr_en[0] = 1'b0;
    chk_reset_state(0, "midreset");
    begin
      bit seen = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (rsp_valid[0] === 1'b1) seen = 1'b1;
      end
      chk("midreset.no_rsp", 32'(seen), 32'd0);
    end
    run_fetch(0, 8'h00, 0, 1'b0, 8'h10, 32'h0000_0006, 8'h05, 1'b0, 5, "post_reset");

    // Randomized fetches against the model, with writes landing on the
    // acceptance edge so the fetch observes the new byte.
    for (int n = 0; n < 80; n++) begin
      int sel = int'($urandom_range(0, 1));
      logic [7:0] pc = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] wa = ($urandom_range(0, 1) == 1) ? pc + 8'($urandom_range(0, 4)) : 8'($urandom);
        logic [7:0] wd = ($urandom_range(0, 2) == 0) ? 8'h10 : 8'($urandom);
        wr_en[sel] = 1'b1; wr_addr[sel] = wa; wr_data[sel] = wd;
        mwrite(sel, wa, wd);
      end
      predict(sel, pc, p_ins, p_c, p_np, p_er, p_lat);
      run_fetch(sel, pc, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                p_ins, p_c, p_np, p_er, p_lat, $sformatf("rnd%0d_d%0d", n, sel));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
